mux4to1_rr_scheduler: RTL and testbench
=======================================

# mux4to1_rr_scheduler

Round-robin scheduler that shares one 4:1 multiplexer output channel among four requesters. It arbitrates the `req` lines and drives the mux `sel` with a registered value. It gates the selected lane onto a valid/ready output channel and bounds each grant to `MAX_HOLD` accepted beats, so a requester holding `req` high cannot starve the others. It sits in front of `mux4to1`: its `sel` feeds the mux, and its output handshake feeds the downstream consumer.

## Interface
- `DATA_W`, default 1: width of each lane. At 1, lane i is `in[i]`, which matches `mux4to1`.
- `MAX_HOLD`, default 4: maximum accepted beats per grant. Legal range is 1..255.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  per-lane request; lane i wants the channel while `req[i]`=1.
- `in`  in  4*DATA_W  lane data; lane i is `in[i*DATA_W +: DATA_W]`.
- `out_ready`  in  1  downstream accepts the beat this cycle.
- `sel`  out  2  registered mux select, binary index of the granted lane.
- `gnt`  out  4  registered one-hot grant; all zero when idle.
- `out`  out  DATA_W  selected lane data; zero when not in GRANT.
- `out_valid`  out  1  beat available on `out`.
- `busy`  out  1  registered; 1 while in GRANT.

## Operation
- FSM has two states, IDLE and GRANT.
- Reset values:
  - state is IDLE.
  - `sel`=2'b00, `gnt`=4'b0000, `busy`=0.
  - `out_valid`=0, `out`=0.
  - beat count is 0.
  - last-grant pointer `last`=3, so lane 0 has highest priority after reset.
- IDLE:
  - If `req`≠0, grant the first requesting lane scanning `last+1, last+2, last+3, last` modulo 4.
  - Load `sel`, `gnt`, set `busy`=1, `last`=granted lane, clear beat count, and go to GRANT.
  - If `req`=0, stay in IDLE with no output change.
- GRANT, combinational outputs:
  - `out_valid` = `req[sel]`.
  - `out` = lane `sel` of `in`.
- Transfer is `out_valid && out_ready`. Each transfer increments the beat count.
- Release to IDLE at the next edge when either:
  - `req[sel]`=0 (requester withdrew; no transfer that cycle), or
  - a transfer occurs and the beat count reaches `MAX_HOLD` after the increment.
- On release, `gnt`←0, `busy`←0, and the beat count clears. `sel` keeps its last value.
- While `out_ready`=0 with `req[sel]`=1, hold the grant indefinitely. There is no timeout, and stalled cycles do not count as beats.
- The beat counter is `$clog2(MAX_HOLD+1)` bits wide and never wraps: release occurs at `MAX_HOLD`.
- `in` changes while granted appear on `out` in the same cycle, with no buffering.
- `req` of non-granted lanes is ignored during GRANT.

## Timing
- Request-to-grant latency: `req` high before edge N gives `gnt`/`sel` updated after edge N, and `out_valid` valid in cycle N+1 (one cycle).
- Every release spends exactly one IDLE cycle. Back-to-back grants therefore have a one-cycle bubble.
- Peak throughput is `MAX_HOLD` beats per `MAX_HOLD+1` cycles.
- `out`/`out_valid` depend combinationally on `req`, `in`, and the registered `sel`/state. There is no path from `out_ready` to `out_valid`.
- Reset asserted mid-grant clears all registered outputs immediately, without waiting for a clock edge. `out_valid`/`out` go to 0 in the same cycle.
- After `rst` deasserts, the first arbitration is at the next rising edge. Priority restarts at lane 0.

## Test plan
- Reset mid-grant: hold lane 2 granted and assert `rst` between edges → `gnt`=0, `sel`=00, and `out_valid`=0 immediately. After release with all `req` high, lane 0 is granted first.
- Single requester, `MAX_HOLD`=4, `req`=4'b0010, `in`=4'b1010, `out_ready`=1:
  - → `sel`=01, `gnt`=0010, `out`=1.
  - → 4 transfers, then 1 IDLE cycle, then lane 1 is re-granted.
- All requesting, `req`=4'b1111, `out_ready`=1, `MAX_HOLD`=2:
  - → grant order is 0,1,2,3,0.
  - → each grant gives 2 beats plus 1 idle cycle, so 12 cycles per rotation.
- Backpressure: lane 3 granted, `out_ready`=0 for 5 cycles, then 1 → grant is held, no beats are counted during the stall, and exactly `MAX_HOLD` transfers are counted after.
- Withdrawal: lane 2 granted, `req[2]` drops after 1 beat while `req[0]` is high → release, one IDLE cycle, then lane 0 is granted. `last`=2 before that grant, so lane 3 would have had priority had it been requesting.

Source files
------------

// File: rtl/mux4to1_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mux4to1_rr_scheduler
// Purpose  : Round-robin scheduler for a shared 4:1 mux output channel.
//            It arbitrates four request lines and drives a registered mux
//            select and one-hot grant. The granted lane is gated onto a
//            valid/ready output channel. Each grant is limited to MAX_HOLD
//            accepted beats, so a requester that holds req high cannot
//            starve the other lanes.
// Ports    : clk        - single clock, rising edge
//            rst        - asynchronous active-high reset
//            req[3:0]   - per-lane request
//            in         - lane data, lane i at in[i*DATA_W +: DATA_W]
//            out_ready  - downstream accepts the beat this cycle
//            sel[1:0]   - registered mux select (binary lane index)
//            gnt[3:0]   - registered one-hot grant, zero when idle
//            out        - selected lane data, zero outside GRANT
//            out_valid  - beat available on out
//            busy       - registered, high while in GRANT
// Revision : 1.0 - initial release
// ============================================================================
module mux4to1_rr_scheduler #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   in,
  input  logic                  out_ready,
  output logic [1:0]            sel,
  output logic [3:0]            gnt,
  output logic [DATA_W-1:0]     out,
  output logic                  out_valid,
  output logic                  busy
);

  // The counter must be able to hold MAX_HOLD itself, so it never wraps.
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] C_MAX_HOLD = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [1:0]       sel_q,   sel_d;
  logic [3:0]       gnt_q,   gnt_d;
  logic             busy_q,  busy_d;
  logic [1:0]       last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // --------------------------------------------------------------------------
  // Lane unpacking
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] lane_data [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_data[gi] = in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin pick: scan last+1, last+2, last+3, last (mod 4).
  // The 2-bit sum wraps naturally, so k=4 lands back on last itself.
  // --------------------------------------------------------------------------
  logic       pick_found;
  logic [1:0] pick_idx;

  always_comb begin
    logic [1:0] idx;
    pick_found = 1'b0;
    pick_idx   = last_q;
    idx        = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output channel. out_valid depends only on req and registered state;
  // out_ready is used solely to decide whether a beat was accepted.
  // --------------------------------------------------------------------------
  logic             lane_req;
  logic             xfer;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    lane_req  = req[sel_q];
    out_valid = (state_q == ST_GRANT) && lane_req;
    xfer      = out_valid && out_ready;
    cnt_inc   = cnt_q + C_CNT_ONE;
    out       = (state_q == ST_GRANT) ? lane_data[sel_q] : '0;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx;
          gnt_d   = 4'b0001 << pick_idx;
          busy_d  = 1'b1;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end

      ST_GRANT: begin
        // Withdrawal wins over everything: no beat is possible that cycle.
        // sel is deliberately left alone on release so the mux stays put.
        if (!lane_req) begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (xfer) begin
          if (cnt_inc == C_MAX_HOLD) begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers. last resets to 3 so that lane 0 is scanned first.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'b00;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mux4to1_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4to1_rr_scheduler
// Purpose  : Directed self-checking bench for mux4to1_rr_scheduler.
//            dut4 runs with MAX_HOLD=4, dut2 with MAX_HOLD=2; both share
//            the same stimulus and each scenario checks one of them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4to1_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] in  = 4'b0000;
  logic       out_ready = 1'b1;

  logic [1:0] sel;
  logic [3:0] gnt;
  logic [0:0] out;
  logic       out_valid;
  logic       busy;

  logic [1:0] sel2;
  logic [3:0] gnt2;
  logic [0:0] out2;
  logic       out_valid2;
  logic       busy2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux4to1_rr_scheduler #(.DATA_W(1), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .in(in), .out_ready(out_ready),
    .sel(sel), .gnt(gnt), .out(out), .out_valid(out_valid), .busy(busy)
  );

  mux4to1_rr_scheduler #(.DATA_W(1), .MAX_HOLD(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .in(in), .out_ready(out_ready),
    .sel(sel2), .gnt(gnt2), .out(out2), .out_valid(out_valid2), .busy(busy2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = 4'b0000;
    in  = 4'b0000;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset;
    rst = 1'b1;
    req = 4'b0000;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    n_cmp++; if (sel !== 2'b00) begin n_bad++; $display("FAIL reset_sel got=%b want=00", sel); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (out_valid !== 1'b0 || out !== 1'b0) begin n_bad++; $display("FAIL reset_out got=%b/%b want=0/0", out_valid, out); end
    @(posedge clk); #1;
    rst = 1'b0;
    req = 4'b0100;
    in  = 4'b0100;
    tick;
    n_cmp++; if (gnt !== 4'b0100 || sel !== 2'b10) begin n_bad++; $display("FAIL reset_pre_grant got=%b/%b want=0100/10", gnt, sel); end
    tick;
    // assert reset between edges while lane 2 is still granted
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (gnt !== 4'b0000 || sel !== 2'b00) begin n_bad++; $display("FAIL reset_mid_gnt got=%b/%b want=0000/00", gnt, sel); end
    n_cmp++; if (out_valid !== 1'b0 || out !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid_out got=%b/%b/%b want=0/0/0", out_valid, out, busy); end
    req = 4'b1111;
    @(posedge clk); #1;
    rst = 1'b0;
    tick;
    n_cmp++; if (gnt !== 4'b0001 || sel !== 2'b00) begin n_bad++; $display("FAIL reset_restart got=%b/%b want=0001/00", gnt, sel); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single;
    int xfers;
    int cyc;
    do_reset;
    req = 4'b0010;
    in  = 4'b1010;
    out_ready = 1'b1;
    n_cmp++; if (out !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL single_idle_out got=%b/%b want=0/0", out, out_valid); end
    tick;
    n_cmp++; if (sel !== 2'b01 || gnt !== 4'b0010) begin n_bad++; $display("FAIL single_grant got=%b/%b want=01/0010", sel, gnt); end
    n_cmp++; if (out !== 1'b1 || out_valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL single_out got=%b/%b/%b want=1/1/1", out, out_valid, busy); end
    // data passes straight through within the cycle
    in = 4'b1000;
    #1;
    n_cmp++; if (out !== 1'b0) begin n_bad++; $display("FAIL single_passthru got=%b want=0", out); end
    in = 4'b1010;
    #1;
    xfers = 0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) xfers++;
      tick;
      cyc++;
    end
    n_cmp++; if (xfers !== 4) begin n_bad++; $display("FAIL single_beats got=%0d want=4", xfers); end
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL single_hold_cycles got=%0d want=4", cyc); end
    n_cmp++; if (gnt !== 4'b0000 || sel !== 2'b01 || out_valid !== 1'b0 || out !== 1'b0) begin n_bad++; $display("FAIL single_release got=%b/%b/%b/%b want=0000/01/0/0", gnt, sel, out_valid, out); end
    tick;
    n_cmp++; if (gnt !== 4'b0010 || busy !== 1'b1) begin n_bad++; $display("FAIL single_regrant got=%b/%b want=0010/1", gnt, busy); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_round_robin;
    logic [3:0] exp_gnt [13];
    exp_gnt = '{4'b0001, 4'b0001, 4'b0000,
                4'b0010, 4'b0010, 4'b0000,
                4'b0100, 4'b0100, 4'b0000,
                4'b1000, 4'b1000, 4'b0000,
                4'b0001};
    do_reset;
    req = 4'b1111;
    in  = 4'b0101;
    out_ready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick;
      n_cmp++; if (gnt2 !== exp_gnt[k]) begin n_bad++; $display("FAIL rr_gnt[%0d] got=%b want=%b", k, gnt2, exp_gnt[k]); end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure;
    int xfers;
    int cyc;
    do_reset;
    req = 4'b1000;
    in  = 4'b1000;
    out_ready = 1'b0;
    tick;
    n_cmp++; if (gnt !== 4'b1000 || sel !== 2'b11) begin n_bad++; $display("FAIL bp_grant got=%b/%b want=1000/11", gnt, sel); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (gnt !== 4'b1000 || out_valid !== 1'b1 || out !== 1'b1) begin n_bad++; $display("FAIL bp_stall[%0d] got=%b/%b/%b want=1000/1/1", i, gnt, out_valid, out); end
      tick;
    end
    out_ready = 1'b1;
    #1;
    xfers = 0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) xfers++;
      tick;
      cyc++;
    end
    n_cmp++; if (xfers !== 4) begin n_bad++; $display("FAIL bp_beats got=%0d want=4", xfers); end
    n_cmp++; if (busy !== 1'b0 || gnt !== 4'b0000) begin n_bad++; $display("FAIL bp_release got=%b/%b want=0/0000", busy, gnt); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_withdraw(input logic [3:0] after_req, input logic [3:0] exp_next);
    do_reset;
    req = 4'b0100;
    in  = 4'b0000;
    out_ready = 1'b1;
    tick;
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL wd_grant got=%b want=0100", gnt); end
    tick;
    req = after_req;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL wd_valid got=%b want=0", out_valid); end
    tick;
    n_cmp++; if (busy !== 1'b0 || gnt !== 4'b0000 || sel !== 2'b10) begin n_bad++; $display("FAIL wd_release got=%b/%b/%b want=0/0000/10", busy, gnt, sel); end
    tick;
    n_cmp++; if (gnt !== exp_next) begin n_bad++; $display("FAIL wd_next req=%b got=%b want=%b", after_req, gnt, exp_next); end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_withdraw(4'b0001, 4'b0001);
    test_withdraw(4'b1001, 4'b1000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
